snake_move_scheduler: RTL and testbench
=======================================

SNAKE_MOVE_SCHEDULER -- requirements
Module: snake_move_scheduler

Interface
REQ-001 Parameters SHALL be: TICK_BASE, default 16, clock cycles per move at speed 0; GRID_W, default 32, grid columns; GRID_H, default 24, grid rows.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 l, r, u, d  input  1 each  level-sensitive direction buttons.
REQ-005 pause  input  1  level-sensitive; high freezes movement.
REQ-006 speed  input  2  move period select; period P = TICK_BASE >> speed.
REQ-007 direction  output  3  committed direction: 000 none, 001 left, 010 right, 011 up, 100 down.
REQ-008 step  output  1  one-cycle pulse per committed move.
REQ-009 head_x  output  5  head column, range 0..GRID_W-1.
REQ-010 head_y  output  5  head row, range 0..GRID_H-1.
REQ-011 state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSED.

Function
REQ-012 Button decode SHALL apply fixed priority l > r > u > d when several buttons are high in the same cycle.
REQ-013 The decoded request SHALL be rejected if it is the exact reverse of the committed direction (left/right, up/down).
REQ-014 A request equal to the committed direction SHALL be accepted and have no effect.
REQ-015 In RUN, each accepted request SHALL overwrite the internal pending-direction register; the last accepted request before a step wins.
REQ-016 In IDLE, direction SHALL be 000, and pause and speed SHALL be ignored.
REQ-017 IDLE to RUN: on the edge sampling the first decoded press, direction and pending SHALL both load that press, cnt SHALL clear, and head SHALL be unchanged.
REQ-018 In RUN, the internal counter cnt SHALL increment each cycle.
REQ-019 When cnt >= P-1 in RUN, the same edge SHALL do all of the following: cnt <= 0; step <= 1; direction <= pending; head moves one cell in the pending direction.
REQ-020 step SHALL be 0 on every other cycle; step, the new direction and the new head are visible in the same cycle.
REQ-021 First step after entering RUN SHALL occur P cycles after the entry edge.
REQ-022 Move deltas SHALL be: left x-1; right x+1; up y-1; down y+1.
REQ-023 Wrap-around SHALL apply: x 0 left -> GRID_W-1; x GRID_W-1 right -> 0; y 0 up -> GRID_H-1; y GRID_H-1 down -> 0.
REQ-024 A speed change SHALL take effect immediately; if cnt >= new P-1, the step SHALL fire at the next edge.
REQ-025 RUN with pause=1 SHALL enter PAUSED at the next edge with no step on that edge; cnt holds.
REQ-026 In PAUSED: step=0, cnt, direction, pending and head hold, and buttons are ignored.
REQ-027 PAUSED with pause=0 SHALL return to RUN at the next edge, with cnt resuming from its held value.
REQ-028 Encoding 11 of state SHALL be unreachable; if entered, the FSM SHALL go to IDLE at the next edge.

Reset
REQ-029 reset=1 at a clock edge SHALL set: state=IDLE, direction=000, pending=000, step=0, cnt=0, head_x=GRID_W/2 (16), head_y=GRID_H/2 (12).
REQ-030 Reset SHALL take priority over all other inputs, including mid-RUN and mid-PAUSED.

Verification (defaults, speed=0 unless stated)
REQ-031 Start: reset, then l=1 for one cycle -> direction=001 and state=01 next cycle; step=1 exactly 16 cycles later with head=(15,12); step=1 again 16 cycles after that with head=(14,12).
REQ-032 Reversal: moving left, press r -> direction stays 001; then press u -> at next step direction=011 and head_y decrements by 1.
REQ-033 Priority and last-wins:
- In IDLE, l=u=1 together -> direction=001.
- In RUN, u then d pressed before a step while moving left -> commit 100.
REQ-034 Wrap and speed:
- speed=3 (P=2), head_x=0 moving left -> next step head_x=31; head_y=0 moving up -> 23.
- Changing speed from 0 to 3 at cnt=10 -> step on the next edge.
REQ-035 Pause: pause=1 at cnt=5 for 20 cycles -> no step and head frozen; after release, next step 11 cycles later.
REQ-036 Reset mid-run: reset asserted during RUN with head=(3,7) -> next cycle state=00, direction=000, step=0, head=(16,12).

Source files
------------

// File: rtl/snake_move_scheduler.sv
// snake_move_scheduler
//   Turns level-sensitive direction buttons into a paced stream of snake
//   moves. A small FSM (IDLE / RUN / PAUSED) owns a move-period counter, the
//   committed direction, a pending direction that buttons may overwrite
//   between moves, and the head position on a wrap-around grid.
//
// Ports
//   clk        : single clock, all state changes on its rising edge
//   reset      : synchronous active-high reset
//   l, r, u, d : direction buttons (level), priority l > r > u > d
//   pause      : level, freezes movement while high in RUN
//   speed[1:0] : move period select, P = TICK_BASE >> speed
//   direction  : committed direction 000 none, 001 L, 010 R, 011 U, 100 D
//   step       : one-cycle pulse on each committed move
//   head_x/y   : head column / row
//   state      : 00 IDLE, 01 RUN, 10 PAUSED
module snake_move_scheduler #(
  parameter int TICK_BASE = 16,
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       l,
  input  logic       r,
  input  logic       u,
  input  logic       d,
  input  logic       pause,
  input  logic [1:0] speed,
  output logic [2:0] direction,
  output logic       step,
  output logic [4:0] head_x,
  output logic [4:0] head_y,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_t;

  localparam logic [2:0] DIR_NONE  = 3'b000;
  localparam logic [2:0] DIR_LEFT  = 3'b001;
  localparam logic [2:0] DIR_RIGHT = 3'b010;
  localparam logic [2:0] DIR_UP    = 3'b011;
  localparam logic [2:0] DIR_DOWN  = 3'b100;

  localparam logic [4:0] X_MAX = 5'(GRID_W - 1);
  localparam logic [4:0] Y_MAX = 5'(GRID_H - 1);
  localparam logic [4:0] X_MID = 5'(GRID_W / 2);
  localparam logic [4:0] Y_MID = 5'(GRID_H / 2);

  // cnt never exceeds the longest period minus one, TICK_BASE - 1
  localparam int CNT_W = (TICK_BASE > 2) ? $clog2(TICK_BASE) : 1;

  state_t           state_r;
  logic [2:0]       direction_r;
  logic [2:0]       pending_r;
  logic             step_r;
  logic [4:0]       head_x_r;
  logic [4:0]       head_y_r;
  logic [CNT_W-1:0] cnt_r;

  logic [2:0]       req_s;
  logic             accept_s;
  logic [31:0]      period_s;
  logic [31:0]      last_s;
  logic             fire_s;
  logic [4:0]       next_x_s;
  logic [4:0]       next_y_s;

  function automatic logic [2:0] reverse_dir(input logic [2:0] dir);
    logic [2:0] rev;
    case (dir)
      DIR_LEFT:  rev = DIR_RIGHT;
      DIR_RIGHT: rev = DIR_LEFT;
      DIR_UP:    rev = DIR_DOWN;
      DIR_DOWN:  rev = DIR_UP;
      default:   rev = DIR_NONE;
    endcase
    return rev;
  endfunction

  // Priority button decode and reversal filter against the committed direction
  always_comb begin
    req_s = DIR_NONE;
    if (l) begin
      req_s = DIR_LEFT;
    end else if (r) begin
      req_s = DIR_RIGHT;
    end else if (u) begin
      req_s = DIR_UP;
    end else if (d) begin
      req_s = DIR_DOWN;
    end else begin
      req_s = DIR_NONE;
    end
    accept_s = (req_s != DIR_NONE) && (req_s != reverse_dir(direction_r));
  end

  // Move period from the live speed input; a speed change acts at once
  always_comb begin
    period_s = 32'(TICK_BASE) >> speed;
    if (period_s == 32'd0) begin
      last_s = 32'd0;
    end else begin
      last_s = period_s - 32'd1;
    end
    fire_s = (32'(cnt_r) >= last_s);
  end

  // Next head position in the pending direction with wrap-around
  always_comb begin
    next_x_s = head_x_r;
    next_y_s = head_y_r;
    case (pending_r)
      DIR_LEFT: begin
        if (head_x_r == 5'd0) next_x_s = X_MAX;
        else                  next_x_s = head_x_r - 5'd1;
      end
      DIR_RIGHT: begin
        if (head_x_r >= X_MAX) next_x_s = 5'd0;
        else                   next_x_s = head_x_r + 5'd1;
      end
      DIR_UP: begin
        if (head_y_r == 5'd0) next_y_s = Y_MAX;
        else                  next_y_s = head_y_r - 5'd1;
      end
      DIR_DOWN: begin
        if (head_y_r >= Y_MAX) next_y_s = 5'd0;
        else                   next_y_s = head_y_r + 5'd1;
      end
      default: begin
        next_x_s = head_x_r;
        next_y_s = head_y_r;
      end
    endcase
  end

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      direction_r <= DIR_NONE;
      pending_r   <= DIR_NONE;
      step_r      <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      head_x_r    <= X_MID;
      head_y_r    <= Y_MID;
    end else begin
      step_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          direction_r <= DIR_NONE;
          if (req_s != DIR_NONE) begin
            state_r     <= ST_RUN;
            direction_r <= req_s;
            pending_r   <= req_s;
            cnt_r       <= {CNT_W{1'b0}};
          end
        end
        ST_RUN: begin
          // pause wins over everything else on this edge: no step, cnt holds
          if (pause) begin
            state_r <= ST_PAUSED;
          end else begin
            if (accept_s) begin
              pending_r <= req_s;
            end
            if (fire_s) begin
              cnt_r       <= {CNT_W{1'b0}};
              step_r      <= 1'b1;
              direction_r <= pending_r;
              head_x_r    <= next_x_s;
              head_y_r    <= next_y_s;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1'b1);
            end
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          direction_r <= DIR_NONE;
          pending_r   <= DIR_NONE;
          cnt_r       <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign direction = direction_r;
  assign step      = step_r;
  assign head_x    = head_x_r;
  assign head_y    = head_y_r;
  assign state     = state_r;

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Directed self-checking bench for snake_move_scheduler (default parameters).
module tb_snake_move_scheduler;

  logic       clk;
  logic       reset;
  logic       l, r, u, d;
  logic       pause;
  logic [1:0] speed;
  logic [2:0] direction;
  logic       step;
  logic [4:0] head_x;
  logic [4:0] head_y;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int n;

  snake_move_scheduler #(
    .TICK_BASE(16),
    .GRID_W   (32),
    .GRID_H   (24)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .l        (l),
    .r        (r),
    .u        (u),
    .d        (d),
    .pause    (pause),
    .speed    (speed),
    .direction(direction),
    .step     (step),
    .head_x   (head_x),
    .head_y   (head_y),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold buttons {l,r,u,d} for exactly one edge
  task automatic press(input logic [3:0] btn);
    {l, r, u, d} = btn;
    tick();
    {l, r, u, d} = 4'b0000;
  endtask

  // Edges until step is seen (1-based); max+1 on timeout
  task automatic wait_step(input int max, output int cnt);
    cnt = max + 1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (step === 1'b1) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic count_steps(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (step === 1'b1) cnt++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    {l, r, u, d} = 4'b0000;
    pause = 1'b0;
    speed = 2'd0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    check_val("rst_state", state, 2'b00);
    check_val("rst_dir", direction, 3'b000);
    check_val("rst_step", step, 1'b0);
    check_val("rst_hx", head_x, 5'd16);
    check_val("rst_hy", head_y, 5'd12);

    // IDLE ignores pause and speed
    pause = 1'b1;
    speed = 2'd3;
    tick();
    check_val("idle_state", state, 2'b00);
    check_val("idle_dir", direction, 3'b000);
    pause = 1'b0;
    speed = 2'd0;

    // start left, first step 16 edges after entry, then every 16
    press(4'b1000);
    check_val("start_dir", direction, 3'b001);
    check_val("start_state", state, 2'b01);
    check_val("start_step", step, 1'b0);
    check_val("start_hx", head_x, 5'd16);
    wait_step(40, n);
    check_val("first_lat", n, 16);
    check_val("first_hx", head_x, 5'd15);
    check_val("first_hy", head_y, 5'd12);
    tick();
    check_val("step_pulse", step, 1'b0);
    wait_step(40, n);
    check_val("second_lat", n, 15);
    check_val("second_hx", head_x, 5'd14);

    // reversal rejected, then turn up
    press(4'b0100);
    check_val("rev_dir", direction, 3'b001);
    wait_step(40, n);
    check_val("rev_lat", n, 15);
    check_val("rev_hx", head_x, 5'd13);
    check_val("rev_dir2", direction, 3'b001);
    press(4'b0010);
    wait_step(40, n);
    check_val("up_dir", direction, 3'b011);
    check_val("up_hy", head_y, 5'd11);
    check_val("up_hx", head_x, 5'd13);

    // last accepted request wins: left, then u and d before the step
    press(4'b1000);
    wait_step(40, n);
    check_val("left_dir", direction, 3'b001);
    check_val("left_hx", head_x, 5'd12);
    press(4'b0010);
    press(4'b0001);
    wait_step(40, n);
    check_val("last_dir", direction, 3'b100);
    check_val("last_hy", head_y, 5'd12);
    check_val("last_hx", head_x, 5'd12);

    // priority l over u in IDLE, then all four wraps at P=2
    do_reset();
    speed = 2'd3;
    press(4'b1010);
    check_val("prio_dir", direction, 3'b001);
    for (int i = 0; i < 16; i++) wait_step(8, n);
    check_val("wrapl_hx0", head_x, 5'd0);
    wait_step(8, n);
    check_val("p2_lat", n, 2);
    check_val("wrapl_hx", head_x, 5'd31);
    press(4'b0010);
    for (int i = 0; i < 12; i++) wait_step(8, n);
    check_val("wrapu_hy0", head_y, 5'd0);
    wait_step(8, n);
    check_val("wrapu_hy", head_y, 5'd23);
    check_val("wrapu_hx", head_x, 5'd31);
    check_val("wrapu_dir", direction, 3'b011);
    press(4'b0100);
    wait_step(8, n);
    check_val("wrapr_hx", head_x, 5'd0);
    check_val("wrapr_dir", direction, 3'b010);
    press(4'b0001);
    wait_step(8, n);
    check_val("wrapd_hy", head_y, 5'd0);

    // speed 0 -> 3 at cnt=10 fires on the next edge
    do_reset();
    speed = 2'd0;
    press(4'b1000);
    for (int i = 0; i < 10; i++) tick();
    check_val("spd_nostep", step, 1'b0);
    speed = 2'd3;
    tick();
    check_val("spd_step", step, 1'b1);
    check_val("spd_hx", head_x, 5'd15);
    speed = 2'd0;

    // pause at cnt=5 for 20 cycles, buttons ignored, resume 11 edges later
    for (int i = 0; i < 5; i++) tick();
    pause = 1'b1;
    tick();
    check_val("pause_state", state, 2'b10);
    u = 1'b1;
    count_steps(19, n);
    check_val("pause_steps", n, 0);
    check_val("pause_hx", head_x, 5'd15);
    check_val("pause_hold", state, 2'b10);
    u = 1'b0;
    pause = 1'b0;
    tick();
    check_val("resume_state", state, 2'b01);
    wait_step(30, n);
    check_val("resume_lat", n, 11);
    check_val("resume_hx", head_x, 5'd14);
    check_val("resume_dir", direction, 3'b001);

    // reset from PAUSED
    pause = 1'b1;
    tick();
    check_val("pause2_state", state, 2'b10);
    do_reset();
    pause = 1'b0;
    check_val("rstp_state", state, 2'b00);
    check_val("rstp_hx", head_x, 5'd16);

    // reset mid-run away from the centre
    press(4'b0100);
    wait_step(40, n);
    check_val("run_hx", head_x, 5'd17);
    tick();
    do_reset();
    check_val("rstr_state", state, 2'b00);
    check_val("rstr_dir", direction, 3'b000);
    check_val("rstr_step", step, 1'b0);
    check_val("rstr_hx", head_x, 5'd16);
    check_val("rstr_hy", head_y, 5'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
